apes_rocket_readout: RTL and testbench

Responder side of the APES collect/readout handshake. It waits for `en_rocket_rd` from the sequencing FSM, reads the frozen channel counter bank, and serializes one telemetry frame to the rocket interface: a sync word, then every channel count, then a checksum. It then raises `rdout_done` and holds it until `en_rocket_rd` drops. It sits between the counter bank and the rocket serial link, and is clocked from the 50 MHz system clock.

---
 rtl/apes_pkg.sv | 28 ++
 rtl/apes_rocket_readout_if.sv | 46 ++++
 rtl/apes_bit_timer.sv | 49 ++++
 rtl/apes_rocket_readout.sv | 172 +++++++++++++++++
 tb/tb_apes_rocket_readout.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/apes_pkg.sv
// Shared definitions for the APES rocket readout block.
// Holds the readout FSM state encoding, the telemetry word width, the default
// frame sync pattern and small helpers for address width and frame length.
package apes_pkg;

   localparam int unsigned WordW = 16;

   localparam logic [WordW-1:0] SyncWordDefault = 16'hEB90;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StData,
      StCsum,
      StDone
   } state_e;

   // Counter bank address width; a single-channel bank still gets one bit.
   function automatic int unsigned addr_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Bits per frame: sync word, one word per channel, checksum word.
   function automatic int unsigned frame_bits(input int unsigned num_ch);
      return WordW * (num_ch + 2);
   endfunction

endpackage

// File: rtl/apes_rocket_readout_if.sv
// Readout-side bundle: request/done handshake with the sequencing FSM, the
// counter bank read port, and the rocket serial link.
//   en_rocket_rd : readout request level
//   rdout_done   : frame complete, held until request drops
//   cnt_addr     : counter bank read address
//   cnt_data     : counter bank read data (one cycle after cnt_addr)
//   ser_clk      : serial clock, idles high
//   ser_data     : serial data, MSB first
//   ser_frame    : high for the whole frame
// Modport master is the readout block, slave is its environment.
interface apes_rocket_readout_if #(
   parameter int unsigned NUM_CH = 16
) ();
   import apes_pkg::*;

   localparam int unsigned AddrW = addr_width(NUM_CH);

   logic             en_rocket_rd;
   logic             rdout_done;
   logic [AddrW-1:0] cnt_addr;
   logic [WordW-1:0] cnt_data;
   logic             ser_clk;
   logic             ser_data;
   logic             ser_frame;

   modport master (
      input  en_rocket_rd,
      input  cnt_data,
      output rdout_done,
      output cnt_addr,
      output ser_clk,
      output ser_data,
      output ser_frame
   );

   modport slave (
      output en_rocket_rd,
      output cnt_data,
      input  rdout_done,
      input  cnt_addr,
      input  ser_clk,
      input  ser_data,
      input  ser_frame
   );

endinterface

// File: rtl/apes_bit_timer.sv
// Half-bit divider for the rocket serial link.
//   clk50     : system clock
//   rst_n     : asynchronous active-low reset
//   start     : reload at frame start (low phase, count 0)
//   en        : run while a frame is active; when low, idle with ser_clk high
//   bit_start : next edge begins a new bit (ser_clk falls)
//   half      : next edge ends the low half-bit (ser_clk rises)
//   ser_clk   : serial clock level, low for the first half of each bit
module apes_bit_timer #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic clk50,
   input  logic rst_n,
   input  logic start,
   input  logic en,
   output logic bit_start,
   output logic half,
   output logic ser_clk
);

   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

   logic [CntW-1:0] cnt_q;
   logic            phase_q;

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (start) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (!en) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (cnt_q == CntLast) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign bit_start = phase_q && (cnt_q == CntLast);
   assign half      = !phase_q && (cnt_q == CntLast);
   assign ser_clk   = phase_q;

endmodule

// File: rtl/apes_rocket_readout.sv
// APES rocket readout responder. On a readout request it reads the frozen
// channel counter bank and serializes one frame: sync word, NUM_CH channel
// counts, then a 16-bit wrap-around checksum of the counts. rdout_done is
// raised at frame end and held until the request is withdrawn.
//   clk50 : 50 MHz system clock
//   rst_n : asynchronous active-low reset
//   bus   : request/done, counter bank read port, serial link (master side)
module apes_rocket_readout
   import apes_pkg::*;
#(
   parameter int unsigned      NUM_CH    = 16,
   parameter int unsigned      CLK_DIV   = 25,
   parameter logic [WordW-1:0] SYNC_WORD = SyncWordDefault
) (
   input logic                   clk50,
   input logic                   rst_n,
   apes_rocket_readout_if.master bus
);

   localparam int unsigned AddrW = addr_width(NUM_CH);
   localparam logic [AddrW-1:0] LastIdx = AddrW'(NUM_CH - 1);

   state_e           state_q, state_d;
   logic [WordW-1:0] shift_q, shift_d;
   logic [WordW-1:0] hold_q, hold_d;
   logic [WordW-1:0] csum_q, csum_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [AddrW-1:0] word_idx_q, word_idx_d;
   logic [AddrW-1:0] addr_q, addr_d;
   // Read pipeline: bit 0 set on address issue, capture when it reaches bit 1,
   // which covers a registered bank with one cycle of read latency.
   logic [1:0]       fetch_q, fetch_d;

   logic             tmr_start;
   logic             tmr_en;
   logic             bit_start;
   logic             half;
   logic             ser_clk_w;
   logic             load;
   logic [AddrW-1:0] load_idx;

   apes_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .clk50     (clk50),
      .rst_n     (rst_n),
      .start     (tmr_start),
      .en        (tmr_en),
      .bit_start (bit_start),
      .half      (half),
      .ser_clk   (ser_clk_w)
   );

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         hold_q     <= '0;
         csum_q     <= '0;
         bit_cnt_q  <= '0;
         word_idx_q <= '0;
         addr_q     <= '0;
         fetch_q    <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         csum_q     <= csum_d;
         bit_cnt_q  <= bit_cnt_d;
         word_idx_q <= word_idx_d;
         addr_q     <= addr_d;
         fetch_q    <= fetch_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      csum_d     = csum_q;
      bit_cnt_d  = bit_cnt_q;
      word_idx_d = word_idx_q;
      addr_d     = addr_q;
      fetch_d    = {fetch_q[0], 1'b0};
      tmr_start  = 1'b0;
      load       = 1'b0;
      load_idx   = '0;

      if (fetch_q[1]) begin
         hold_d = bus.cnt_data;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.en_rocket_rd) begin
               state_d    = StSync;
               shift_d    = SYNC_WORD;
               csum_d     = '0;
               bit_cnt_d  = '0;
               word_idx_d = '0;
               addr_d     = '0;
               fetch_d    = 2'b01;
               tmr_start  = 1'b1;
            end
         end
         StSync, StData, StCsum: begin
            if (!bus.en_rocket_rd) begin
               // Abort: drop back to idle with reset-valued outputs.
               state_d = StIdle;
               shift_d = '0;
               addr_d  = '0;
               fetch_d = '0;
            end else if (bit_start) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               shift_d   = {shift_q[WordW-2:0], 1'b0};
               if (bit_cnt_q == 4'd15) begin
                  if (state_q == StSync) begin
                     state_d  = StData;
                     load     = 1'b1;
                     load_idx = '0;
                  end else if ((state_q == StData) && (word_idx_q != LastIdx)) begin
                     load     = 1'b1;
                     load_idx = word_idx_q + AddrW'(1);
                  end else if (state_q == StData) begin
                     state_d = StCsum;
                     shift_d = csum_q;
                  end else begin
                     state_d = StDone;
                     shift_d = '0;
                     addr_d  = '0;
                  end
               end
            end
         end
         StDone: begin
            if (!bus.en_rocket_rd) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Word load: send the prefetched count, fold it into the checksum and
      // prefetch the following channel during this word's first bit.
      if (load) begin
         shift_d    = hold_q;
         csum_d     = csum_q + hold_q;
         word_idx_d = load_idx;
         if (load_idx != LastIdx) begin
            addr_d     = load_idx + AddrW'(1);
            fetch_d[0] = 1'b1;
         end
      end
   end

   // The divider runs only while the next state is inside a frame; leaving
   // the frame parks ser_clk high on the same edge.
   assign tmr_en = ((state_d == StSync) || (state_d == StData) || (state_d == StCsum))
                   && !tmr_start;

   assign bus.ser_clk    = ser_clk_w;
   assign bus.ser_data   = shift_q[WordW-1];
   assign bus.ser_frame  = (state_q == StSync) || (state_q == StData) || (state_q == StCsum);
   assign bus.rdout_done = (state_q == StDone);
   assign bus.cnt_addr   = addr_q;

   // The rising half-bit strobe can only fire during the low phase.
   assert property (@(posedge clk50) disable iff (!rst_n) half |-> !ser_clk_w);

endmodule

// File: tb/tb_apes_rocket_readout.sv
module tb_apes_rocket_readout;
   import apes_pkg::*;

   localparam int unsigned NumCh    = 4;
   localparam int unsigned ClkDiv   = 2;
   localparam int unsigned FrameCyc = 2 * ClkDiv * frame_bits(NumCh);

   logic clk50 = 1'b0;
   logic rst_n = 1'b0;

   apes_rocket_readout_if #(.NUM_CH(NumCh)) bus ();

   apes_rocket_readout #(
      .NUM_CH    (NumCh),
      .CLK_DIV   (ClkDiv),
      .SYNC_WORD (16'hEB90)
   ) dut (
      .clk50 (clk50),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk50 = ~clk50;

   // Counter bank model with one cycle of read latency.
   logic [15:0] counts [NumCh];
   always @(posedge clk50) bus.cnt_data <= counts[bus.cnt_addr];

   logic [15:0] exp_q [$];
   int          addr_log [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          stable_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Serial receiver: samples on ser_clk rising, pops one expected word per
   // 16 bits, and logs the address sequence seen during the frame.
   initial begin
      logic        prev_clk;
      logic        prev_data;
      logic [15:0] rx_word;
      logic [15:0] exp_w;
      int          rx_bits;
      prev_clk  = 1'b1;
      prev_data = 1'b0;
      rx_word   = '0;
      rx_bits   = 0;
      forever begin
         @(negedge clk50);
         if (!rst_n || !bus.ser_frame) begin
            rx_bits = 0;
         end else begin
            if (prev_clk && bus.ser_clk && (bus.ser_data !== prev_data)) stable_err++;
            if (!prev_clk && bus.ser_clk) begin
               rx_word = {rx_word[14:0], bus.ser_data};
               rx_bits++;
               if (rx_bits == 16) begin
                  rx_bits = 0;
                  check("sb_pending", exp_q.size() != 0, 1);
                  if (exp_q.size() != 0) begin
                     exp_w = exp_q.pop_front();
                     check("rx_word", rx_word, exp_w);
                  end
               end
            end
            if (addr_log.size() == 0 || addr_log[$] != int'(bus.cnt_addr))
               addr_log.push_back(int'(bus.cnt_addr));
         end
         prev_clk  = bus.ser_clk;
         prev_data = bus.ser_data;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk50);
         #1;
      end
   endtask

   // Called #1 after a clock edge; returns #1 after the start edge k.
   task automatic start_frame();
      logic [15:0] sum;
      sum = '0;
      exp_q.delete();
      exp_q.push_back(16'hEB90);
      for (int i = 0; i < NumCh; i++) begin
         exp_q.push_back(counts[i]);
         sum = sum + counts[i];
      end
      exp_q.push_back(sum);
      addr_log.delete();
      stable_err = 0;
      bus.en_rocket_rd = 1'b1;
      tick(1);
      check("start_frame", bus.ser_frame, 1);
      check("start_bit", bus.ser_data, 1);
      check("start_clk", bus.ser_clk, 0);
   endtask

   task automatic finish_frame(input string name);
      int n;
      n = 0;
      while (!bus.rdout_done && n < int'(FrameCyc) + 50) begin
         tick(1);
         n++;
      end
      check({name, "_done_latency"}, n, FrameCyc);
      check({name, "_frame_low"}, bus.ser_frame, 0);
      check({name, "_clk_idle"}, bus.ser_clk, 1);
      check({name, "_data_low"}, bus.ser_data, 0);
      check({name, "_words_left"}, exp_q.size(), 0);
      check({name, "_stable"}, stable_err, 0);
      check({name, "_addr_steps"}, addr_log.size(), NumCh);
      for (int i = 0; i < addr_log.size() && i < NumCh; i++)
         check({name, "_addr_seq"}, addr_log[i], i);
      tick(3);
      check({name, "_done_held"}, bus.rdout_done, 1);
      bus.en_rocket_rd = 1'b0;
      tick(1);
      check({name, "_done_clear"}, bus.rdout_done, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_done"}, bus.rdout_done, 0);
      check({name, "_addr"}, bus.cnt_addr, 0);
      check({name, "_clk"}, bus.ser_clk, 1);
      check({name, "_data"}, bus.ser_data, 0);
      check({name, "_frame"}, bus.ser_frame, 0);
   endtask

   initial begin
      int seen_done;
      bus.en_rocket_rd = 1'b0;
      counts = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      rst_n = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(2);

      // Nominal frame, then two back-to-back frames with a 1-cycle request gap.
      counts = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      start_frame();
      finish_frame("nominal");
      counts = '{16'hFFFF, 16'h0002, 16'h0003, 16'h0001};
      start_frame();
      finish_frame("wrap");
      counts = '{16'h1234, 16'h8000, 16'h8001, 16'h00FF};
      start_frame();
      finish_frame("b2b");

      // Abort at cycle 100 of the frame.
      tick(2);
      counts = '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0};
      start_frame();
      tick(99);
      bus.en_rocket_rd = 1'b0;
      tick(1);
      check("abort_frame", bus.ser_frame, 0);
      check("abort_clk", bus.ser_clk, 1);
      check("abort_data", bus.ser_data, 0);
      check("abort_addr", bus.cnt_addr, 0);
      exp_q.delete();
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.rdout_done) seen_done++;
         tick(1);
      end
      check("abort_no_done", seen_done, 0);

      // Asynchronous reset mid-frame, between clock edges.
      counts = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
      start_frame();
      tick(149);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      bus.en_rocket_rd = 1'b0;
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(2);
      counts = '{16'h7FFF, 16'h0001, 16'hC000, 16'h4000};
      start_frame();
      finish_frame("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
